// File: rtl/dbus_arbiter_if.sv
// Shared data-bus bundle: two requesting masters plus the dmem and io slave ports.
// The arbiter uses the slave view; bus masters and memories use the master view.
interface dbus_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              io_we;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_rdata, m0_ack,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_rdata, m1_ack,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output io_we, io_addr, io_wdata,
    input  io_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  io_we, io_addr, io_wdata,
    output io_rdata
  );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus. Data-memory accesses
// take one cycle; I/O accesses (address bit IO_BIT set) hold the address stable
// for IO_WAIT extra cycles before the write strobe and ack.
module dbus_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int IO_BIT  = 15,
  parameter int IO_WAIT = 2
) (
  input  logic           clock,
  input  logic           reset,
  dbus_arbiter_if.slave  bus,
  output logic           owner,
  output logic           busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_IO   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(IO_WAIT);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [3:0]  cnt_q, cnt_d;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              final_cycle;
  logic              arb_en;
  logic              ack0, ack1;
  logic              pend0, pend1;
  logic              grant_valid;
  logic              grant;
  logic              grant_io;

  // Owner's request fields steer both slave ports.
  assign sel_we    = owner_q ? bus.m1_we    : bus.m0_we;
  assign sel_addr  = owner_q ? bus.m1_addr  : bus.m0_addr;
  assign sel_wdata = owner_q ? bus.m1_wdata : bus.m0_wdata;

  // Completion cycle: every MEM cycle, or the IO cycle whose counter reached zero.
  assign final_cycle = (state_q == ST_MEM) || ((state_q == ST_IO) && (cnt_q == 4'd0));
  assign arb_en      = (state_q == ST_IDLE) || final_cycle;
  assign ack0        = final_cycle && !owner_q;
  assign ack1        = final_cycle &&  owner_q;

  // The master being acked this cycle still holds req, so it is not pending.
  assign pend0       = bus.m0_req && !ack0;
  assign pend1       = bus.m1_req && !ack1;
  assign grant_valid = pend0 || pend1;
  assign grant       = (pend0 && pend1) ? !last_q : pend1;
  assign grant_io    = grant ? bus.m1_addr[IO_BIT] : bus.m0_addr[IO_BIT];

  // State, grant history and wait counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate when idle or finishing, otherwise count down IO.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (arb_en) begin
      if (grant_valid) begin
        owner_d = grant;
        last_d  = grant;
        state_d = grant_io ? ST_IO : ST_MEM;
        cnt_d   = grant_io ? WAIT_INIT : 4'd0;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_IO) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // Bus outputs: each slave port is driven only in its own state, zero otherwise.
  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.io_we     = 1'b0;
    bus.io_addr   = '0;
    bus.io_wdata  = '0;
    bus.m0_ack    = ack0;
    bus.m1_ack    = ack1;
    bus.m0_rdata  = '0;
    bus.m1_rdata  = '0;
    if (state_q == ST_MEM) begin
      bus.mem_we    = sel_we;
      bus.mem_addr  = sel_addr;
      bus.mem_wdata = sel_wdata;
      if (ack0) bus.m0_rdata = bus.mem_rdata;
      if (ack1) bus.m1_rdata = bus.mem_rdata;
    end else if (state_q == ST_IO) begin
      bus.io_we    = sel_we && final_cycle;
      bus.io_addr  = sel_addr;
      bus.io_wdata = sel_wdata;
      if (ack0) bus.m0_rdata = bus.io_rdata;
      if (ack1) bus.m1_rdata = bus.io_rdata;
    end
  end

  assign owner = owner_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus randomized
// traffic from both masters, checked every cycle against a transaction model.
module tb_dbus_arbiter;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 32;
  localparam int IO_BIT  = 15;
  localparam int IO_WAIT = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic owner, busy;

  always #5 clock = ~clock;

  dbus_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  dbus_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .IO_BIT(IO_BIT), .IO_WAIT(IO_WAIT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .owner(owner),
    .busy(busy)
  );

  // Master request registers, driven by the issue task.
  logic [1:0]  req = 2'b00;
  logic [1:0]  we  = 2'b00;
  logic [31:0] addr  [2] = '{default: 32'h0};
  logic [31:0] wdata [2] = '{default: 32'h0};

  assign bus.m0_req   = req[0];
  assign bus.m0_we    = we[0];
  assign bus.m0_addr  = addr[0];
  assign bus.m0_wdata = wdata[0];
  assign bus.m1_req   = req[1];
  assign bus.m1_we    = we[1];
  assign bus.m1_addr  = addr[1];
  assign bus.m1_wdata = wdata[1];

  // Data memory and I/O block behind the arbiter.
  logic [31:0] dmem [64] = '{default: 32'h0};
  always @(posedge clock) if (bus.mem_we) dmem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = dmem[bus.mem_addr[7:2]];
  assign bus.io_rdata  = bus.io_addr ^ 32'h5A5A_0000;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one in-flight access with a remaining-cycle count.
  bit          m_valid = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_io    = 1'b0;
  bit          m_last  = 1'b1;
  int          m_left  = 0;
  logic [31:0] ref_mem [64] = '{default: 32'h0};
  int          exp_writes = 0;
  int          seen_writes = 0;
  int          seen_io_we = 0;

  always @(negedge clock) begin : scoreboard
    bit          o, fin, g;
    logic [1:0]  e_ack, pend;
    logic [31:0] e_rd [2];
    logic [64:0] e_mem, e_io;
    if (!reset) begin
      m_valid = 1'b0;
      m_owner = 1'b0;
      m_last  = 1'b1;
    end
    o     = m_owner;
    fin   = m_valid && (m_left == 1);
    e_ack = 2'b00;
    e_rd[0] = 32'h0;
    e_rd[1] = 32'h0;
    e_mem = '0;
    e_io  = '0;
    if (m_valid && !m_io) e_mem = {we[o], addr[o], wdata[o]};
    if (m_valid &&  m_io) e_io  = {we[o] && fin, addr[o], wdata[o]};
    if (fin) begin
      e_ack[o] = 1'b1;
      e_rd[o]  = m_io ? (addr[o] ^ 32'h5A5A_0000) : ref_mem[addr[o][7:2]];
    end
    check("busy",     busy, m_valid);
    check("acks",     {bus.m1_ack, bus.m0_ack}, e_ack);
    check("m0_rdata", bus.m0_rdata, e_rd[0]);
    check("m1_rdata", bus.m1_rdata, e_rd[1]);
    check("mem_port", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, e_mem);
    check("io_port",  {bus.io_we, bus.io_addr, bus.io_wdata}, e_io);
    if (m_valid || !reset) check("owner", owner, o);
    if (bus.mem_we === 1'b1) seen_writes++;
    if (bus.io_we === 1'b1) begin
      seen_writes++;
      seen_io_we++;
    end
    if (reset) begin
      if (fin && we[o]) begin
        exp_writes++;
        if (!m_io) ref_mem[addr[o][7:2]] = wdata[o];
      end
      if (!m_valid || fin) begin
        pend = req & ~(fin ? (2'b01 << o) : 2'b00);
        if (pend != 2'b00) begin
          g       = (pend == 2'b11) ? !m_last : pend[1];
          m_valid = 1'b1;
          m_owner = g;
          m_last  = g;
          m_io    = addr[g][IO_BIT];
          m_left  = m_io ? IO_WAIT + 1 : 1;
        end else begin
          m_valid = 1'b0;
        end
      end else begin
        m_left--;
      end
    end
  end

  // Raise a request, hold it until the matching ack, then drop it after the edge.
  task automatic issue(input int m, input bit w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd);
    bit got;
    we[m]    = w;
    addr[m]  = a;
    wdata[m] = d;
    req[m]   = 1'b1;
    got      = 1'b0;
    rd       = 32'h0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clock);
      if (((m == 0) ? bus.m0_ack : bus.m1_ack) === 1'b1) begin
        got = 1'b1;
        rd  = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
      end
    end
    if (!got) check("ack_timeout", got, 1'b1);
    @(posedge clock);
    #1;
    req[m] = 1'b0;
  endtask

  task automatic random_master(input int m, input int count);
    logic [31:0] a, rd;
    int gap;
    for (int i = 0; i < count; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 1) gap = 0;
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
      a = $urandom & 32'h0000_00FC;
      if ($urandom_range(0, 2) == 0) a = a | 32'h0000_8000;
      issue(m, 1'($urandom), a, $urandom, rd);
    end
  endtask

  logic [31:0] rd0, rd1;
  int          io_we_before;
  bit          io_seen;

  initial begin
    // Reset held with both masters requesting: everything stays quiet.
    repeat (2) @(posedge clock);
    #1;
    fork
      issue(0, 1'b0, 32'h0000_0010, 32'h0, rd0);
      issue(1, 1'b0, 32'h0000_0020, 32'h0, rd1);
      begin
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
      end
    join

    // MEM write followed by read-back through master 0.
    issue(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, rd0);
    issue(0, 1'b0, 32'h0000_0040, 32'h0, rd0);
    check("readback", rd0, 32'hDEAD_BEEF);

    // I/O write with wait states from master 1.
    io_we_before = seen_io_we;
    issue(1, 1'b1, 32'h0000_8000, 32'h5, rd1);
    check("io_we_pulses", seen_io_we - io_we_before, 1);

    // Both masters requesting continuously: round-robin over six accesses.
    fork
      for (int i = 0; i < 3; i++) issue(0, 1'b0, 32'h0000_0040 + 32'(4 * i), 32'h0, rd0);
      for (int i = 0; i < 3; i++) issue(1, 1'b1, 32'h0000_0080 + 32'(4 * i), 32'h1000 + 32'(i), rd1);
    join

    // Mixed regions requested together.
    fork
      issue(0, 1'b0, 32'h0000_0010, 32'h0, rd0);
      issue(1, 1'b0, 32'h0000_8004, 32'h0, rd1);
    join
    check("mixed_io_rdata", rd1, 32'h5A5A_8004);

    // Reset during the second IO cycle aborts the access; the held request restarts it.
    io_we_before = seen_io_we;
    io_seen      = 1'b0;
    fork
      issue(1, 1'b1, 32'h0000_8008, 32'h77, rd1);
      begin
        for (int n = 0; n < 20 && !io_seen; n++) begin
          @(negedge clock);
          if (bus.io_addr === 32'h0000_8008) io_seen = 1'b1;
        end
        check("io_start_seen", io_seen, 1'b1);
        @(posedge clock);
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b1;
      end
    join
    check("io_we_after_abort", seen_io_we - io_we_before, 1);

    // Randomized traffic from both masters.
    fork
      random_master(0, 60);
      random_master(1, 60);
    join
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("write_strobes", seen_writes, exp_writes);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
